// File: rtl/shared_adder_arbiter_if.sv
// Request/response bundle for shared_adder_arbiter: NREQ packed operand lanes in,
// one registered sum/carry/id response out, plus the busy flag.
interface shared_adder_arbiter_if #(
   parameter int N    = 24,
   parameter int NREQ = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   rsp_valid;
   logic              rsp_ready;
   logic [N-1:0]      rsp_sum;
   logic              rsp_carry;
   logic [IDW-1:0]    rsp_id;
   logic              busy;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
   );
endinterface

// File: rtl/shared_adder_arbiter.sv
// Shares one RippleCarryAdder between NREQ clients with round-robin grant and a
// programmable settle delay. Define ADDER_ARB_FIXED_PRIO_EN for fixed priority.
module RippleCarryAdder #(
   parameter int n = 24
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         cin,
   output logic [n-1:0] sum,
   output logic         cout
);
   always_comb begin
      logic carry;
      carry = cin;
      sum   = '0;
      for (int i = 0; i < n; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end
endmodule

module shared_adder_arbiter #(
   parameter int N      = 24,
   parameter int NREQ   = 4,
   parameter int SETTLE = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   shared_adder_arbiter_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    op_a_q, op_a_d;
   logic [N-1:0]    op_b_q, op_b_d;
   logic [N-1:0]    rsp_sum_q, rsp_sum_d;
   logic            rsp_carry_q, rsp_carry_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic            busy_q, busy_d;

   logic [N-1:0]    add_sum;
   logic            add_cout;
   logic            found;
   logic [IDW-1:0]  winner;
   logic [NREQ-1:0] grant_oh;

   // The adder only ever sees the latched operands, so clients may change theirs freely.
   RippleCarryAdder #(.n(N)) u_adder (
      .a    (op_a_q),
      .b    (op_b_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

`ifdef ADDER_ARB_FIXED_PRIO_EN
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req_valid[k]) begin
            found  = 1'b1;
            winner = IDW'(k);
         end
      end
   end
`else
   logic [IDW-1:0] last_grant_q, last_grant_d;

   // Scanned from the farthest offset down so the nearest requester after last_grant wins.
   always_comb begin
      logic [IDW-1:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(last_grant_q) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      last_grant_d = (state_q == ST_IDLE && found) ? winner : last_grant_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= IDW'(NREQ - 1);
      else        last_grant_q <= last_grant_d;
   end
`endif

   assign grant_oh = found ? (NREQ'(1) << winner) : '0;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_carry_d = rsp_carry_q;
      rsp_id_d    = rsp_id_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               op_a_d   = bus.req_a[winner*N +: N];
               op_b_d   = bus.req_b[winner*N +: N];
               rsp_id_d = winner;
               cnt_d    = CNT_LOAD;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               rsp_sum_d   = add_sum;
               rsp_carry_d = add_cout;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP) ? (NREQ'(1) << rsp_id_d) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_sum_q   <= '0;
         rsp_carry_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Grant is combinational; it is forced low while reset is held.
   assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? grant_oh : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_carry = rsp_carry_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed and table-driven bench for shared_adder_arbiter (N=8, NREQ=4) with
// SETTLE=2 and SETTLE=1 instances; honours ADDER_ARB_FIXED_PRIO_EN.
module tb_shared_adder_arbiter;
   localparam int N    = 8;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   shared_adder_arbiter_if #(.N(N), .NREQ(NREQ)) b2 ();
   shared_adder_arbiter_if #(.N(N), .NREQ(NREQ)) b1 ();

   shared_adder_arbiter #(.N(N), .NREQ(NREQ), .SETTLE(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2)
   );

   shared_adder_arbiter #(.N(N), .NREQ(NREQ), .SETTLE(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   typedef struct {
      int         client;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] expSum;
      logic       expCarry;
   } vec_t;

   vec_t vecs[6];
   int   passCount  = 0;
   int   checkCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Drives one request on the SETTLE=2 instance at a falling edge and checks the grant.
   task automatic applyStimulus(input int c, input logic [7:0] a, input logic [7:0] b, input string tag);
      @(negedge clk);
      b2.req_a[c*N +: N] = a;
      b2.req_b[c*N +: N] = b;
      b2.req_valid       = NREQ'(1) << c;
      #1 checkOutput({tag, " req_ready"}, 32'(b2.req_ready), 32'(1) << c);
      @(negedge clk);
      b2.req_valid = '0;
      checkOutput({tag, " busy after accept"}, 32'(b2.busy), 32'd1);
      checkOutput({tag, " rsp_valid in settle"}, 32'(b2.rsp_valid), 32'd0);
   endtask

   task automatic runVector(input vec_t v, input string tag);
      applyStimulus(v.client, v.a, v.b, tag);
      @(negedge clk);
      checkOutput({tag, " rsp_valid settle2"}, 32'(b2.rsp_valid), 32'd0);
      @(negedge clk);
      checkOutput({tag, " rsp_valid"}, 32'(b2.rsp_valid), 32'(1) << v.client);
      checkOutput({tag, " rsp_sum"}, 32'(b2.rsp_sum), 32'(v.expSum));
      checkOutput({tag, " rsp_carry"}, 32'(b2.rsp_carry), 32'(v.expCarry));
      checkOutput({tag, " rsp_id"}, 32'(b2.rsp_id), 32'(v.client));
      b2.rsp_ready = 1'b1;
      @(negedge clk);
      b2.rsp_ready = 1'b0;
      checkOutput({tag, " rsp_valid after handshake"}, 32'(b2.rsp_valid), 32'd0);
      checkOutput({tag, " busy after handshake"}, 32'(b2.busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int grantId[5];
      int grantCycle[5];
      int nGrants;
      int expRr[5];
      int badCycles;
      logic [NREQ-1:0] expHsGrant;

      vecs[0] = '{2, 8'hF0, 8'h20, 8'h10, 1'b1};
      vecs[1] = '{0, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[2] = '{3, 8'hFF, 8'hFF, 8'hFE, 1'b1};
      vecs[3] = '{1, 8'h7F, 8'h01, 8'h80, 1'b0};
      vecs[4] = '{3, 8'hAA, 8'h55, 8'hFF, 1'b0};
      vecs[5] = '{0, 8'h80, 8'h80, 8'h00, 1'b1};

`ifdef ADDER_ARB_FIXED_PRIO_EN
      expRr      = '{0, 0, 0, 0, 0};
      expHsGrant = 4'b0001;
`else
      expRr      = '{0, 1, 2, 3, 0};
      expHsGrant = 4'b0100;
`endif

      rst_n        = 1'b0;
      b2.req_valid = '0;
      b2.req_a     = '0;
      b2.req_b     = '0;
      b2.rsp_ready = 1'b0;
      b1.req_valid = '0;
      b1.req_a     = '0;
      b1.req_b     = '0;
      b1.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset req_ready", 32'(b2.req_ready), 32'd0);
      checkOutput("reset rsp_valid", 32'(b2.rsp_valid), 32'd0);
      checkOutput("reset rsp_sum", 32'(b2.rsp_sum), 32'd0);
      checkOutput("reset rsp_carry", 32'(b2.rsp_carry), 32'd0);
      checkOutput("reset rsp_id", 32'(b2.rsp_id), 32'd0);
      checkOutput("reset busy", 32'(b2.busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // All clients request continuously with the response always accepted.
      nGrants      = 0;
      grantId      = '{-1, -1, -1, -1, -1};
      grantCycle   = '{-1, -1, -1, -1, -1};
      b2.rsp_ready = 1'b1;
      b2.req_valid = 4'hF;
      for (int k = 0; k <= 16; k++) begin
         #1;
         if (b2.req_ready != '0) begin
            if (nGrants < 5) begin
               for (int j = 0; j < NREQ; j++) if (b2.req_ready[j]) grantId[nGrants] = j;
               grantCycle[nGrants] = k;
            end
            nGrants++;
         end
         @(negedge clk);
      end
      b2.req_valid = '0;
      repeat (4) @(negedge clk);
      b2.rsp_ready = 1'b0;
      checkOutput("rr grant count", 32'(nGrants), 32'd5);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("rr grant %0d client", i), 32'(grantId[i]), 32'(expRr[i]));
         checkOutput($sformatf("rr grant %0d cycle", i), 32'(grantCycle[i]), 32'(4 * i));
      end
      checkOutput("rr drained busy", 32'(b2.busy), 32'd0);

      for (int i = 0; i < 6; i++) runVector(vecs[i], $sformatf("vec%0d", i));

      // Backpressure with other clients requesting throughout.
      applyStimulus(1, 8'h01, 8'hFF, "bp");
      repeat (2) @(negedge clk);
      b2.req_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         #1;
         checkOutput($sformatf("bp%0d rsp_valid", k), 32'(b2.rsp_valid), 32'h2);
         checkOutput($sformatf("bp%0d rsp_sum", k), 32'(b2.rsp_sum), 32'h00);
         checkOutput($sformatf("bp%0d rsp_carry", k), 32'(b2.rsp_carry), 32'd1);
         checkOutput($sformatf("bp%0d busy", k), 32'(b2.busy), 32'd1);
         checkOutput($sformatf("bp%0d req_ready", k), 32'(b2.req_ready), 32'd0);
         @(negedge clk);
      end
      b2.rsp_ready = 1'b1;
      #1 checkOutput("hs cycle req_ready", 32'(b2.req_ready), 32'd0);
      @(negedge clk);
      checkOutput("hs rsp_valid cleared", 32'(b2.rsp_valid), 32'd0);
      checkOutput("hs busy cleared", 32'(b2.busy), 32'd0);
      #1 checkOutput("hs next grant", 32'(b2.req_ready), 32'(expHsGrant));
      b2.req_valid = '0;
      b2.rsp_ready = 1'b0;

      // Operands change under the held request after the grant.
      applyStimulus(3, 8'h10, 8'h20, "iso");
      b2.req_a[3*N +: N] = 8'hFF;
      b2.req_b[3*N +: N] = 8'hFF;
      repeat (2) @(negedge clk);
      checkOutput("iso rsp_valid", 32'(b2.rsp_valid), 32'h8);
      checkOutput("iso rsp_sum", 32'(b2.rsp_sum), 32'h30);
      checkOutput("iso rsp_carry", 32'(b2.rsp_carry), 32'd0);
      checkOutput("iso rsp_id", 32'(b2.rsp_id), 32'd3);
      b2.rsp_ready = 1'b1;
      @(negedge clk);
      b2.rsp_ready = 1'b0;

      // Reset one cycle after a grant.
      applyStimulus(0, 8'h01, 8'h02, "rst");
      rst_n = 1'b0;
      #1;
      checkOutput("midrst req_ready", 32'(b2.req_ready), 32'd0);
      checkOutput("midrst rsp_valid", 32'(b2.rsp_valid), 32'd0);
      checkOutput("midrst rsp_sum", 32'(b2.rsp_sum), 32'd0);
      checkOutput("midrst rsp_carry", 32'(b2.rsp_carry), 32'd0);
      checkOutput("midrst rsp_id", 32'(b2.rsp_id), 32'd0);
      checkOutput("midrst busy", 32'(b2.busy), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      badCycles = 0;
      b2.rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (b2.rsp_valid != '0 || b2.busy) badCycles++;
      end
      b2.rsp_ready = 1'b0;
      checkOutput("postrst spurious response cycles", 32'(badCycles), 32'd0);

      // SETTLE=1 instance: result two cycles after the request cycle.
      for (int it = 0; it < 8; it++) begin
         int         c;
         logic [7:0] a;
         logic [7:0] b;
         logic [8:0] full;
         c    = int'($urandom_range(0, NREQ - 1));
         a    = 8'($urandom);
         b    = 8'($urandom);
         full = {1'b0, a} + {1'b0, b};
         @(negedge clk);
         b1.req_a[c*N +: N] = a;
         b1.req_b[c*N +: N] = b;
         b1.req_valid       = NREQ'(1) << c;
         #1 checkOutput($sformatf("s1 it%0d req_ready", it), 32'(b1.req_ready), 32'(1) << c);
         @(negedge clk);
         b1.req_valid = '0;
         checkOutput($sformatf("s1 it%0d rsp_valid early", it), 32'(b1.rsp_valid), 32'd0);
         @(negedge clk);
         checkOutput($sformatf("s1 it%0d rsp_valid", it), 32'(b1.rsp_valid), 32'(1) << c);
         checkOutput($sformatf("s1 it%0d rsp_sum", it), 32'(b1.rsp_sum), 32'(full[7:0]));
         checkOutput($sformatf("s1 it%0d rsp_carry", it), 32'(b1.rsp_carry), 32'(full[8]));
         checkOutput($sformatf("s1 it%0d rsp_id", it), 32'(b1.rsp_id), 32'(c));
         b1.rsp_ready = 1'b1;
         @(negedge clk);
         b1.rsp_ready = 1'b0;
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
